// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier issue stage: default widths, FSM states
// and the watchdog counter sizing rule.
package mult_pkg;

  localparam int DEF_A_WIDTH = 4;
  localparam int DEF_B_WIDTH = 4;
  localparam int DEF_P_WIDTH = 8;
  localparam int DEF_TIMEOUT = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  function automatic int watchdog_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int DEF_WD_WIDTH = watchdog_width(DEF_TIMEOUT);

endpackage

// File: rtl/mult_operand_fifo.sv
// Synchronous operand-pair FIFO with a registered occupancy count; full/empty
// are decoded from the count only, so they never depend on same-cycle inputs.
module mult_operand_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue stage for the sequential multiplier: queues operand pairs, starts the core,
// captures its product behind a valid/ready slot and abandons hung operations.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int A_WIDTH    = DEF_A_WIDTH,
  parameter int B_WIDTH    = DEF_B_WIDTH,
  parameter int P_WIDTH    = DEF_P_WIDTH,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] in_a,
  input  logic [B_WIDTH-1:0] in_b,
  output logic               mul_start,
  output logic [A_WIDTH-1:0] mul_a,
  output logic [B_WIDTH-1:0] mul_b,
  input  logic               mul_done,
  input  logic [P_WIDTH-1:0] mul_product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] out_product,
  output logic               busy,
  output logic               timeout
);

  localparam int WD_W   = watchdog_width(TIMEOUT);
  localparam int PAIR_W = A_WIDTH + B_WIDTH;

  state_t            state;
  state_t            next_state;
  logic [WD_W-1:0]   wd;
  logic [WD_W-1:0]   wd_inc;
  logic              wd_expired;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              fifo_push;
  logic [PAIR_W-1:0] head;

  assign in_ready   = !fifo_full;
  assign fifo_push  = in_valid && in_ready;
  assign busy       = (state != IDLE) || !fifo_empty;
  assign wd_inc     = wd + WD_W'(1);
  // Compared on the incremented value so the flag rises TIMEOUT+1 cycles after ISSUE.
  assign wd_expired = (wd_inc == WD_W'(TIMEOUT));

  mult_operand_fifo #(
    .WIDTH(PAIR_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata({in_a, in_b}),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !out_valid) begin
          fifo_pop   = 1'b1;
          next_state = ISSUE;
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (mul_done || wd_expired) begin
          next_state = IDLE;
        end else begin
          next_state = WAIT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand hold, start pulse, watchdog, result slot and sticky timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      wd          <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      timeout     <= 1'b0;
    end else begin
      mul_start <= (next_state == ISSUE);
      if (fifo_pop) begin
        {mul_a, mul_b} <= head;
      end
      if (state == ISSUE) begin
        wd <= '0;
      end else if (state == WAIT) begin
        wd <= wd_inc;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // out_valid is never high in WAIT, so a capture cannot collide with a handshake.
      if (state == WAIT && mul_done) begin
        out_product <= mul_product;
        out_valid   <= 1'b1;
      end else if (state == WAIT && wd_expired) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a behavioural multiplier core model.
module tb_mult_issue_ctrl;

  localparam int TO = 31;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       mul_start;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic       mul_done = 1'b0;
  logic [7:0] mul_product = 8'd0;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_product;
  logic       busy;
  logic       timeout;

  mult_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_product(mul_product),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_product(out_product),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: done pulse core_delay cycles after the start cycle, product a*b.
  logic       core_en = 1'b1;
  int         core_delay = 10;
  logic       force_done = 1'b0;
  logic [7:0] force_prod = 8'd0;
  logic       core_act = 1'b0;
  int         core_cnt = 0;
  logic [3:0] core_a = 4'd0;
  logic [3:0] core_b = 4'd0;
  int         start_cnt = 0;
  int         last_done_cyc = -1;
  int         min_gap = 1000;

  always @(negedge clk) begin
    mul_done    <= force_done;
    mul_product <= force_prod;
    if (reset) begin
      core_act <= 1'b0;
    end else if (mul_start) begin
      core_act  <= 1'b1;
      core_cnt  <= 1;
      core_a    <= mul_a;
      core_b    <= mul_b;
      start_cnt <= start_cnt + 1;
      if (last_done_cyc >= 0 && (cyc - last_done_cyc) < min_gap) min_gap <= cyc - last_done_cyc;
    end else if (core_act) begin
      core_cnt <= core_cnt + 1;
      if (core_en && core_cnt == core_delay) begin
        mul_done      <= 1'b1;
        mul_product   <= {4'd0, core_a} * {4'd0, core_b};
        core_act      <= 1'b0;
        last_done_cyc <= cyc;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!mul_start && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic wait_out(input string name, input logic [7:0] exp);
    int n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    chk({name, "_valid"}, out_valid, 1);
    chk(name, out_product, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_clr"}, out_valid, 0);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int   t0;
    int   sc;
    int   n;
    logic saw;

    vecs[0] = '{4'd3,  4'd5,  8'd15};
    vecs[1] = '{4'd15, 4'd15, 8'd225};
    vecs[2] = '{4'd0,  4'd7,  8'd0};
    vecs[3] = '{4'd1,  4'd1,  8'd1};
    vecs[4] = '{4'd10, 4'd12, 8'd120};
    vecs[5] = '{4'd15, 4'd1,  8'd15};
    vecs[6] = '{4'd8,  4'd8,  8'd64};
    vecs[7] = '{4'd7,  4'd9,  8'd63};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = 4'd0;
    in_b      = 4'd0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_product", out_product, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    // Single operation: start latency, pulse width, result latency.
    sc = start_cnt;
    t0 = cyc;
    push(4'd3, 4'd5);
    wait_start();
    chk("single_start_lat", cyc - t0, 2);
    step();
    chk("single_start_pulse", mul_start, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("single_out_lat", cyc - last_done_cyc, 1);
    wait_out("single", 8'd15);
    chk("single_one_start", start_cnt - sc, 1);

    // Max operands with operand stability through the whole operation.
    push(4'd15, 4'd15);
    wait_start();
    n = 0;
    while (!out_valid && n < 50) begin
      chk("max_hold_a", mul_a, 15);
      chk("max_hold_b", mul_b, 15);
      step();
      n++;
    end
    wait_out("max", 8'd225);

    for (int i = 0; i < 8; i++) begin
      push(vecs[i].a, vecs[i].b);
      wait_out($sformatf("vec%0d", i), vecs[i].p);
    end

    // Backpressure: FIFO fills, result slot blocks further issue.
    push(4'd2, 4'd2);
    push(4'd3, 4'd3);
    push(4'd4, 4'd4);
    chk("bp_full", in_ready, 0);
    push(4'd8, 4'd8);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    sc = start_cnt;
    for (int i = 0; i < 20; i++) step();
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_product", out_product, 4);
    chk("bp_no_start", start_cnt - sc, 0);
    chk("bp_still_full", in_ready, 0);
    wait_out("bp0", 8'd4);
    wait_out("bp1", 8'd9);
    wait_out("bp2", 8'd16);
    for (int i = 0; i < 30; i++) step();
    chk("bp_no_extra", out_valid, 0);
    chk("bp_idle", busy, 0);

    // Simultaneous push and pop with one entry queued.
    push(4'd2, 4'd3);
    push(4'd3, 4'd4);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("pp_first", out_product, 6);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    push(4'd5, 4'd5);
    chk("pp_in_ready", in_ready, 1);
    chk("pp_issue", mul_start, 1);
    push(4'd6, 4'd6);
    chk("pp_count_two", in_ready, 0);
    wait_out("pp1", 8'd12);
    wait_out("pp2", 8'd25);
    wait_out("pp3", 8'd36);

    // Watchdog: the core never answers the first operation.
    core_en = 1'b0;
    push(4'd6, 4'd6);
    push(4'd7, 4'd7);
    wait_start();
    t0  = cyc;
    saw = 1'b0;
    n   = 0;
    while (!timeout && n < 100) begin
      step();
      n++;
      if (out_valid) saw = 1'b1;
    end
    chk("wd_latency", cyc - t0, TO + 1);
    chk("wd_no_out", saw, 0);
    core_en = 1'b1;
    wait_out("wd_next", 8'd49);
    chk("wd_sticky", timeout, 1);

    // Reset in WAIT with a second pair queued, then a late done.
    push(4'd5, 4'd5);
    wait_start();
    step();
    step();
    push(4'd9, 4'd9);
    reset = 1'b1;
    #1;
    chk("mid_rst_start", mul_start, 0);
    chk("mid_rst_a", mul_a, 0);
    chk("mid_rst_b", mul_b, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_product", out_product, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    step();
    reset = 1'b0;
    sc = start_cnt;
    force_done = 1'b1;
    force_prod = 8'd25;
    step();
    force_done = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) saw = 1'b1;
    end
    chk("late_done_ignored", saw, 0);
    chk("flushed_no_issue", start_cnt - sc, 0);
    chk("flushed_busy", busy, 0);

    chk("min_done_to_start", (min_gap >= 2), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
